scan_8seg: RTL and testbench

Time-multiplexed scan controller for a bank of common-cathode 8-segment digits.
- Drives one shared decode_8seg-style decoder: feeds it tetrade, dot and oe, and drives the one-hot digit-select lines.
- Double-buffers the displayed value so a new value is applied only at a frame boundary. This gives tear-free updates.
- Inserts a blanking interval at each digit switch to suppress ghosting.

---
 rtl/scan_8seg.sv | 169 ++++++++++++++++
 tb/tb_scan_8seg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/scan_8seg.sv
// Time-multiplexed scan controller for a bank of common-cathode 8-segment digits.
// Optional leading-zero blanking: define SCAN_8SEG_LZB_EN.
module scan_8seg #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dots,
  input  logic                  load,
  output logic [3:0]            tetrade,
  output logic                  dot,
  output logic                  oe,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame
);
  localparam int CW = $clog2(PRESCALE);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t              state, nxt_state;
  logic [CW-1:0]       cnt, nxt_cnt;
  logic [DW-1:0]       dig, nxt_dig;
  logic [4*DIGITS-1:0] pv, nxt_pv, shv, nxt_shv;
  logic [DIGITS-1:0]   pd, nxt_pd, shd, nxt_shd;
  logic                pvalid, nxt_pvalid;

  logic [3:0]          o_tet;
  logic                o_dot, o_oe, o_frame;
  logic [DIGITS-1:0]   o_sel;
  logic                last_cnt, bnd;

  assign last_cnt = (cnt == CNT_LAST);
  assign bnd      = last_cnt && (dig == DIG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dig       <= '0;
      pv        <= '0;
      pd        <= '0;
      pvalid    <= 1'b0;
      shv       <= '0;
      shd       <= '0;
      tetrade   <= '0;
      dot       <= 1'b0;
      oe        <= 1'b0;
      digit_sel <= '0;
      frame     <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      dig       <= nxt_dig;
      pv        <= nxt_pv;
      pd        <= nxt_pd;
      pvalid    <= nxt_pvalid;
      shv       <= nxt_shv;
      shd       <= nxt_shd;
      tetrade   <= o_tet;
      dot       <= o_dot;
      oe        <= o_oe;
      digit_sel <= o_sel;
      frame     <= o_frame;
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_dig    = dig;
    nxt_pv     = pv;
    nxt_pd     = pd;
    nxt_pvalid = pvalid;
    nxt_shv    = shv;
    nxt_shd    = shd;
    case (state)
      S_IDLE: begin
        nxt_cnt    = '0;
        nxt_dig    = '0;
        nxt_pvalid = 1'b0;
        if (load) begin
          nxt_shv = value;
          nxt_shd = dots;
        end
        if (en) nxt_state = (BLANK > 0) ? S_BLANK : S_SHOW;
      end
      default: begin
        if (!en) begin
          // Leaving the scan: whatever was pending becomes the displayed value.
          nxt_state  = S_IDLE;
          nxt_cnt    = '0;
          nxt_dig    = '0;
          nxt_pvalid = 1'b0;
          if (load) begin
            nxt_shv = value;
            nxt_shd = dots;
          end else if (pvalid) begin
            nxt_shv = pv;
            nxt_shd = pd;
          end
        end else begin
          if (bnd) begin
            nxt_pvalid = 1'b0;
            if (load) begin
              nxt_shv = value;
              nxt_shd = dots;
            end else if (pvalid) begin
              nxt_shv = pv;
              nxt_shd = pd;
            end
          end else if (load) begin
            nxt_pv     = value;
            nxt_pd     = dots;
            nxt_pvalid = 1'b1;
          end
          if (last_cnt) begin
            nxt_cnt = '0;
            nxt_dig = (dig == DIG_LAST) ? '0 : dig + 1'b1;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
          nxt_state = (int'(nxt_cnt) < BLANK) ? S_BLANK : S_SHOW;
        end
      end
    endcase
  end

  // Outputs are derived from next-cycle state so the registers line up with it.
  always_comb begin
    o_tet   = '0;
    o_dot   = 1'b0;
    o_oe    = 1'b0;
    o_sel   = '0;
    o_frame = (nxt_state != S_IDLE) && (nxt_dig == DIG_LAST) && (nxt_cnt == CNT_LAST);
`ifdef SCAN_8SEG_LZB_EN
    begin
      logic allz;
      allz = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        allz = allz && (nxt_shv[4*i +: 4] == 4'd0) && !nxt_shd[i];
        if (nxt_state == S_SHOW && nxt_dig == DW'(i)) begin
          o_tet = nxt_shv[4*i +: 4];
          o_dot = nxt_shd[i];
          if (!(allz && i != 0)) begin
            o_oe     = 1'b1;
            o_sel[i] = 1'b1;
          end
        end
      end
    end
`else
    for (int i = 0; i < DIGITS; i++) begin
      if (nxt_state == S_SHOW && nxt_dig == DW'(i)) begin
        o_tet    = nxt_shv[4*i +: 4];
        o_dot    = nxt_shd[i];
        o_oe     = 1'b1;
        o_sel[i] = 1'b1;
      end
    end
`endif
  end
endmodule

// File: tb/tb_scan_8seg.sv
// Bench for scan_8seg: directed scenarios then random traffic, checked every cycle
// against a time-based model of the scan (frame position derived from elapsed clocks).
module tb_scan_8seg;
  localparam int D = 4, P = 8, B = 2, FL = D * P;

  logic          clk = 1'b0;
  logic          rst, en, load;
  logic [15:0]   value;
  logic [3:0]    dots;
  logic [3:0]    tetrade;
  logic          dot, oe, frame;
  logic [3:0]    digit_sel;

  int checks = 0, errors = 0;

  // model: t = clocks since scan start (-1 when idle)
  int          t;
  logic [15:0] disp, pv;
  logic [3:0]  ddots, pdots;
  logic        pend;

  scan_8seg #(.DIGITS(D), .PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .rst(rst), .en(en), .value(value), .dots(dots), .load(load),
    .tetrade(tetrade), .dot(dot), .oe(oe), .digit_sel(digit_sel), .frame(frame)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] expect_out();
    logic [3:0] tt, sel;
    logic       dt, o, f;
    int         pos, d;
    bit         lzb;
    tt = 0; sel = 0; dt = 0; o = 0; f = 0;
    if (t >= 0) begin
      pos = t % P;
      d   = (t / P) % D;
      f   = ((t % FL) == FL - 1);
      if (pos >= B) begin
        tt  = disp[4*d +: 4];
        dt  = ddots[d];
        lzb = 0;
`ifdef SCAN_8SEG_LZB_EN
        lzb = (d > 0);
        for (int k = d; k < D; k++)
          if (disp[4*k +: 4] != 0 || ddots[k]) lzb = 0;
`endif
        if (!lzb) begin
          o   = 1;
          sel = 4'(1 << d);
        end
      end
    end
    return {tt, dt, o, sel, f};
  endfunction

  task automatic step(input logic r, input logic e, input logic l,
                      input logic [15:0] v, input logic [3:0] dd);
    logic [10:0] exp_v;
    rst = r; en = e; load = l; value = v; dots = dd;
    @(posedge clk);
    if (r) begin
      t = -1; disp = 0; ddots = 0; pend = 0; pv = 0; pdots = 0;
    end else if (t < 0) begin
      if (l) begin disp = v; ddots = dd; end
      pend = 0;
      if (e) t = 0;
    end else if (!e) begin
      if (l) begin disp = v; ddots = dd; end
      else if (pend) begin disp = pv; ddots = pdots; end
      pend = 0;
      t = -1;
    end else begin
      if ((t % FL) == FL - 1) begin
        if (l) begin disp = v; ddots = dd; end
        else if (pend) begin disp = pv; ddots = pdots; end
        pend = 0;
      end else if (l) begin
        pv = v; pdots = dd; pend = 1;
      end
      t++;
    end
    #1;
    exp_v = expect_out();
    checks++;
    assert ({tetrade, dot, oe, digit_sel, frame} === exp_v)
      else begin
        errors++;
        $error("FAIL out t=%0d got tet=%h dot=%b oe=%b sel=%b frm=%b exp tet=%h dot=%b oe=%b sel=%b frm=%b",
               t, tetrade, dot, oe, digit_sel, frame,
               exp_v[10:7], exp_v[6], exp_v[5], exp_v[4:1], exp_v[0]);
      end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 16'h0, 4'h0);
  endtask

  // advance with en=1 until model phase t%m == target (bounded)
  task automatic seek(input int m, input int target);
    int n;
    n = 0;
    while (!(t >= 0 && (t % m) == target) && n < 200) begin
      step(0, 1, 0, 16'h0, 4'h0);
      n++;
    end
    checks++;
    assert (n < 200) else begin
      errors++;
      $error("FAIL seek timeout got %0d exp <200", n);
    end
  endtask

  initial begin
    t = -1; disp = 0; ddots = 0; pend = 0; pv = 0; pdots = 0;
    rst = 1; en = 0; load = 0; value = 0; dots = 0;
    step(1, 0, 0, 16'h0, 4'h0);
    step(1, 0, 0, 16'h0, 4'h0);
    step(0, 0, 0, 16'h0, 4'h0);
    // explicit reset-state check
    checks++;
    assert ({tetrade, dot, oe, digit_sel, frame} === 11'h0)
      else begin errors++; $error("FAIL reset got %h exp 0", {tetrade, dot, oe, digit_sel, frame}); end

    // idle load then scan
    step(0, 0, 1, 16'h1234, 4'h0);
    run(3 * FL);
    // mid-frame load while digit 1 is on
    seek(FL, 10);
    step(0, 1, 1, 16'hABCD, 4'h0);
    run(2 * FL);
    // last load wins
    seek(FL, 3);
    step(0, 1, 1, 16'h1111, 4'h0);
    seek(FL, 20);
    step(0, 1, 1, 16'h2222, 4'h0);
    run(2 * FL);
    // load on the frame=1 cycle
    seek(FL, FL - 1);
    checks++;
    assert (frame === 1'b1) else begin errors++; $error("FAIL bnd_frame got %b exp 1", frame); end
    step(0, 1, 1, 16'h5555, 4'h0);
    run(FL + 8);
    // en drop mid-slot, re-enable
    seek(P, 5);
    step(0, 0, 0, 16'h0, 4'h0);
    step(0, 0, 0, 16'h0, 4'h0);
    run(FL + 4);
    // pending data committed on disable
    seek(FL, 12);
    step(0, 1, 1, 16'h9876, 4'hA);
    step(0, 0, 0, 16'h0, 4'h0);
    run(FL + 2);
    // reset mid-SHOW
    seek(P, 5);
    step(1, 1, 0, 16'h0, 4'h0);
    step(0, 0, 1, 16'h0042, 4'h0);
    run(2 * FL);
    // leading zero patterns
    seek(FL, 6);
    step(0, 1, 1, 16'h0000, 4'h0);
    run(2 * FL);
    seek(FL, 6);
    step(0, 1, 1, 16'h0000, 4'h8);
    run(2 * FL);
    seek(FL, 6);
    step(0, 1, 1, 16'h0070, 4'h0);
    run(2 * FL);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] rv;
      rv = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rv = rv & 16'h00FF;
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 49) != 0),
           ($urandom_range(0, 9) == 0), rv, 4'($urandom_range(0, 15) & ($urandom_range(0, 1) ? 4'hF : 4'h1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
